// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: op encoding, flag bundle, default width
// and the one-bit full-adder cell used to build carry chains.
package alu_pkg;

    localparam int   XLEN   = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
    } alu_flags_t;

    // Flag state of an empty pipeline: the all-zero sum reads as zero.
    localparam alu_flags_t FLAGS_RESET = '{carry: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};

    // Full-adder cell, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The sat lane exists only when PIPE_ADDSUB_SAT_EN is defined.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef PIPE_ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;

    // Issue/writeback side: drives operands, consumes results.
    modport master (
        output in_valid, op_sub, cin, a, b,
`ifdef PIPE_ADDSUB_SAT_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, carry, ovf, zero, neg
    );

    // Adder side.
    modport slave (
        input  in_valid, op_sub, cin, a, b,
`ifdef PIPE_ADDSUB_SAT_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, carry, ovf, zero, neg
    );

endinterface

// File: rtl/addsub_slice.sv
// Combinational C-bit ripple slice. Exposes the carry into the slice MSB so
// the top slice can derive signed overflow as cm ^ co.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int C = 8
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         ci,
    output logic [C-1:0] s,
    output logic         co,
    output logic         cm
);
    logic [C:0] c_s;

    // Ripple the carry through a chain of full-adder cells.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = ci;
        for (int i = 0; i < C; i++) begin
            {c_s[i+1], s[i]} = full_add(a[i], b[i], c_s[i]);
        end
    end

    assign co = c_s[C];
    assign cm = c_s[C-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready backpressure.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; each stage
// registers its slice sum, its carry-out and the operand bits still to be
// consumed. Partial sums shift right by one slice per stage so the final
// stage holds the aligned result.
// Optional feature: define PIPE_ADDSUB_SAT_EN for signed saturation (sat lane).
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave bus
);
    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipe_addsub: WIDTH must be >= 2 and a multiple of STAGES");
        end
    endgenerate

    // Stage registers (index k = output of stage k).
    logic             v_r    [STAGES];
    logic [WIDTH-1:0] psum_r [STAGES];
    logic [WIDTH-1:0] a_sk_r [STAGES];
    logic [WIDTH-1:0] b_sk_r [STAGES];
    logic             cy_r   [STAGES];
    alu_flags_t       flags_r;

    // Inputs seen by each stage.
    logic             src_v_s   [STAGES];
    logic [WIDTH-1:0] src_a_s   [STAGES];
    logic [WIDTH-1:0] src_b_s   [STAGES];
    logic [WIDTH-1:0] src_sum_s [STAGES];
    logic             src_c_s   [STAGES];

    logic [C-1:0]     sl_sum_s  [STAGES];
    logic             sl_co_s   [STAGES];
    logic             sl_cm_s   [STAGES];
    logic [WIDTH-1:0] nxt_sum_s [STAGES];

    logic             adv_s;
    logic             ovf_raw_s;
    logic [WIDTH-1:0] fin_sum_s;
    alu_flags_t       flags_nxt_s;

`ifdef PIPE_ADDSUB_SAT_EN
    logic             sat_r     [STAGES];
    logic             src_sat_s [STAGES];
`endif

    // Whole pipeline moves together; a held result freezes every stage.
    assign adv_s        = !v_r[L] || bus.out_ready;
    assign bus.in_ready = adv_s;

    // Stage 0 takes the bus (b inverted and carry forced for subtract); later stages take their predecessor.
    always_comb begin
        src_v_s[0]   = bus.in_valid;
        src_a_s[0]   = bus.a;
        src_b_s[0]   = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
        src_c_s[0]   = (bus.op_sub == OP_SUB) ? 1'b1 : bus.cin;
        src_sum_s[0] = '0;
`ifdef PIPE_ADDSUB_SAT_EN
        src_sat_s[0] = bus.sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k]   = v_r[k-1];
            src_a_s[k]   = a_sk_r[k-1];
            src_b_s[k]   = b_sk_r[k-1];
            src_c_s[k]   = cy_r[k-1];
            src_sum_s[k] = psum_r[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
            src_sat_s[k] = sat_r[k-1];
`endif
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            addsub_slice #(.C(C)) u_slice (
                .a  (src_a_s[k][C-1:0]),
                .b  (src_b_s[k][C-1:0]),
                .ci (src_c_s[k]),
                .s  (sl_sum_s[k]),
                .co (sl_co_s[k]),
                .cm (sl_cm_s[k])
            );
        end
    endgenerate

    // Shift the partial sum down one slice and insert this stage's slice at the top.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum_s[k] = (src_sum_s[k] >> C) | (WIDTH'(sl_sum_s[k]) << (WIDTH - C));
        end
    end

    // Final stage: overflow from the MSB carries, optional clamp, then flags from the stored value.
    always_comb begin
        ovf_raw_s = sl_co_s[L] ^ sl_cm_s[L];
        fin_sum_s = nxt_sum_s[L];
`ifdef PIPE_ADDSUB_SAT_EN
        if (src_sat_s[L] && ovf_raw_s) begin
            if (src_a_s[L][C-1]) begin
                fin_sum_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                fin_sum_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            fin_sum_s = nxt_sum_s[L];
        end
`endif
        flags_nxt_s.carry = sl_co_s[L];
        flags_nxt_s.ovf   = ovf_raw_s;
        flags_nxt_s.zero  = (fin_sum_s == '0);
        flags_nxt_s.neg   = fin_sum_s[WIDTH-1];
    end

    // Pipeline registers: cleared asynchronously, advanced only when the output side is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k]    <= 1'b0;
                psum_r[k] <= '0;
                a_sk_r[k] <= '0;
                b_sk_r[k] <= '0;
                cy_r[k]   <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
                sat_r[k]  <= 1'b0;
`endif
            end
            flags_r <= FLAGS_RESET;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k]    <= src_v_s[k];
                a_sk_r[k] <= src_a_s[k] >> C;
                b_sk_r[k] <= src_b_s[k] >> C;
                cy_r[k]   <= sl_co_s[k];
`ifdef PIPE_ADDSUB_SAT_EN
                sat_r[k]  <= src_sat_s[k];
`endif
            end
            for (int k = 0; k < L; k++) begin
                psum_r[k] <= nxt_sum_s[k];
            end
            psum_r[L] <= fin_sum_s;
            flags_r   <= flags_nxt_s;
        end
    end

    assign bus.out_valid = v_r[L];
    assign bus.sum       = psum_r[L];
    assign bus.carry     = flags_r.carry;
    assign bus.ovf       = flags_r.ovf;
    assign bus.zero      = flags_r.zero;
    assign bus.neg       = flags_r.neg;

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
- Generalises the fixed 32-bit ripple adder in three ways: configurable width, a carry chain split across registered pipeline stages, and an add/sub mode select.
- Produces carry, overflow, zero and negative flags, and uses a valid/ready handshake so it can sit between issue and writeback with backpressure.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be ≥2.
- STAGES, 4: number of pipeline register stages, which is also the number of carry-chain slices. WIDTH % STAGES must be 0; any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- op_sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, cin forced to 1).
- cin  input  1  carry-in; ignored when op_sub=1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry  output  1  carry-out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

Interface note: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Slice width C = WIDTH/STAGES. Stage k adds bits [k*C +: C] using the carry registered by stage k-1. Stage 0 uses cin, or 1 when op_sub=1.
- Operand bits not yet consumed travel forward in skew registers. Already-computed sum slices are carried forward alongside them.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, with no stalls.
- Throughput: one operation per cycle.
- Stall rule: the pipeline advances iff !out_valid || out_ready. in_ready equals that same advance condition.
  - While stalled, every stage register holds its value.
  - Operand inputs are don't-care when in_valid=0.
- Bubbles: each stage carries its own valid bit. Bubbles propagate and never produce out_valid.
- Flags are registered with sum and held stable while out_valid && !out_ready.
  - ovf = (a[msb] == b'[msb]) && (sum[msb] != a[msb]), where b' = ~b for sub and b otherwise.
- Reset (async assert, any time, including mid-stream):
  - All valid bits clear, so out_valid=0 immediately.
  - sum, carry, ovf, neg = 0; zero = 1. All skew registers = 0.
  - in_ready = 1 from the first clock after deassertion.
- STAGES=1 gives a single registered ripple adder with latency 1.
- Simultaneous accept and output on the same cycle is legal and sustains full rate.

Optional Feature:
- Macro: PIPE_ADDSUB_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), registered alongside the operands.
  - On the final stage, if sat=1 and ovf=1, sum is clamped to the signed max (0111…1) when a[msb]=0, else to the signed min (100…0).
  - ovf still reports the raw overflow. zero and neg are computed from the clamped value.
- Undefined: no sat port and no clamping logic; results always wrap modulo 2^WIDTH.

Decomposition:
- Package alu_pkg:
  - Op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
  - Flag-bundle typedef or struct {carry, ovf, zero, neg}.
  - Default-width constant XLEN=32.
- One sub-module: addsub_slice (parameter C). A combinational C-bit ripple built from the existing full-adder cell, with carry-in, carry-out, and the MSB-level carry-in exposed for overflow detection.
- The top level instantiates STAGES slices plus the pipeline, skew and valid registers.

Test Plan (WIDTH=32, STAGES=4 unless stated):
1. add 0xFFFFFFFF+0x00000001, cin=0 -> after 4 cycles sum=0, carry=1, zero=1, ovf=0, neg=0.
2. sub 5-7 -> sum=0xFFFFFFFE, carry=0, neg=1, ovf=0. Then sub 7-5 -> sum=2, carry=1.
3. add 0x000000FF+0x00000001 (crosses the slice boundary at bit 8) -> sum=0x00000100. Also add 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1. With PIPE_ADDSUB_SAT_EN and sat=1 -> sum=0x7FFFFFFF, ovf=1.
4. Push 8 back-to-back ops with out_ready=0 for cycles 5-7 -> in_ready drops while stalled, no result lost or duplicated, outputs in issue order, flags stable during the stall.
5. Assert rst_n=0 while 3 ops are in flight -> out_valid=0 asynchronously. After release, no stale result ever appears and the next op returns after 4 cycles.
6. STAGES=1 and WIDTH=8: 0x80+0x80 -> 1-cycle latency, sum=0x00, carry=1, ovf=1, zero=1.
